// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared types and constants for the HSMC ADC SPI
// configuration controller (FSM states, frame layout, target bits).
package adc_spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_e;

  localparam int          FRAME_BITS  = 24;
  localparam logic [12:0] UPDATE_ADDR = 13'h0FF;
  localparam logic [7:0]  UPDATE_DATA = 8'h01;

  localparam int TGT_A = 0;
  localparam int TGT_B = 1;

  // Write-only, one-byte frame: {W=0, W1:W0=00, addr, data}
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [12:0] addr,
    input logic [7:0]  data
  );
    return {1'b0, 2'b00, addr, data};
  endfunction

endpackage

// File: rtl/adc_spi_config_ctrl_shift.sv
// adc_spi_shift: 24-bit MSB-first shifter with SCLK generation.
// Ports: clk, rst, load/frame (start), run (keep clocking),
// sclk/sdio (registered), last_bit (final falling edge is now).
module adc_spi_shift
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  run,
  output logic                  sclk,
  output logic                  sdio,
  output logic                  last_bit
);

  localparam int TW = $clog2(CLK_DIV) + 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(CLK_DIV - 1);

  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [4:0]            bit_q, bit_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic                  sclk_q, sclk_d;
  logic                  sdio_q, sdio_d;
  logic                  half_end;

  assign half_end = (tick_q == TICK_MAX);
  // bit 0 high phase ends on this edge
  assign last_bit = half_end && sclk_q && (bit_q == 5'd0);

  always_comb begin
    sr_d   = sr_q;
    bit_d  = bit_q;
    tick_d = tick_q;
    sclk_d = sclk_q;
    sdio_d = sdio_q;
    if (load) begin
      sr_d   = frame;
      bit_d  = 5'(FRAME_BITS - 1);
      tick_d = '0;
      sclk_d = 1'b0;
      sdio_d = frame[FRAME_BITS-1];
    end else if (!run) begin
      tick_d = '0;
      sclk_d = 1'b0;
      sdio_d = 1'b1;
    end else if (half_end) begin
      tick_d = '0;
      sclk_d = ~sclk_q;
      // next bit goes out with the falling edge
      if (sclk_q && (bit_q != 5'd0)) begin
        sr_d   = {sr_q[FRAME_BITS-2:0], 1'b0};
        sdio_d = sr_q[FRAME_BITS-2];
        bit_d  = bit_q - 5'd1;
      end
    end else begin
      tick_d = tick_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      bit_q  <= '0;
      tick_q <= '0;
      sclk_q <= 1'b0;
      sdio_q <= 1'b1;
    end else begin
      sr_q   <= sr_d;
      bit_q  <= bit_d;
      tick_q <= tick_d;
      sclk_q <= sclk_d;
      sdio_q <= sdio_d;
    end
  end

  assign sclk = sclk_q;
  assign sdio = sdio_q;

endmodule

// File: rtl/adc_spi_config_ctrl.sv
// adc_spi_config_ctrl: serialises single-register writes to the two
// HSMC ADCs over shared SCLK/SDIO with per-channel chip selects.
// Ports: cmd_* handshake + fields in; busy/done/frame_count status;
// spi_sclk/spi_sdio/spi_cs_a_n/spi_cs_b_n registered pin drives.
module adc_spi_config_ctrl
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int GAP_CYCLES  = 8,
  parameter bit AUTO_UPDATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_target,
  input  logic [12:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_count,
  output logic        spi_sclk,
  output logic        spi_sdio,
  output logic        spi_cs_a_n,
  output logic        spi_cs_b_n
);

  localparam int CNT_MAX =
    (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] H_LOAD   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    tgt_q, tgt_d;
  logic          upd_q, upd_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          cs_a_n_q, cs_a_n_d;
  logic          cs_b_n_q, cs_b_n_d;

  logic                  accept;
  logic                  sh_load;
  logic                  sh_run;
  logic                  sh_last;
  logic [FRAME_BITS-1:0] sh_frame;

  assign accept = cmd_valid && cmd_ready_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tgt_d         = tgt_q;
    upd_d         = upd_q;
    done_d        = 1'b0;
    frame_count_d = frame_count_q;
    cs_a_n_d      = cs_a_n_q;
    cs_b_n_d      = cs_b_n_q;
    sh_load       = 1'b0;
    sh_frame      = build_frame(cmd_addr, cmd_data);
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          tgt_d = cmd_target;
          if (cmd_target == 2'b00) begin
            // nothing to send: one-cycle pass through GAP
            state_d = S_GAP;
            cnt_d   = '0;
            upd_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d  = S_SETUP;
            cnt_d    = H_LOAD;
            upd_d    = AUTO_UPDATE;
            sh_load  = 1'b1;
            cs_a_n_d = ~cmd_target[TGT_A];
            cs_b_n_d = ~cmd_target[TGT_B];
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) state_d = S_SHIFT;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_SHIFT: begin
        if (sh_last) begin
          state_d = S_HOLD;
          cnt_d   = H_LOAD;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d       = S_GAP;
          cnt_d         = GAP_LOAD;
          cs_a_n_d      = 1'b1;
          cs_b_n_d      = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          done_d        = ~upd_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          if (upd_q) begin
            state_d  = S_SETUP;
            cnt_d    = H_LOAD;
            upd_d    = 1'b0;
            sh_load  = 1'b1;
            sh_frame = build_frame(UPDATE_ADDR, UPDATE_DATA);
            cs_a_n_d = ~tgt_q[TGT_A];
            cs_b_n_d = ~tgt_q[TGT_B];
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // keep SCLK running for the whole CS-low window
  assign sh_run = (state_d == S_SETUP) ||
                  (state_d == S_SHIFT) ||
                  (state_d == S_HOLD);

  adc_spi_shift #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .frame    (sh_frame),
    .run      (sh_run),
    .sclk     (spi_sclk),
    .sdio     (spi_sdio),
    .last_bit (sh_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      tgt_q         <= '0;
      upd_q         <= 1'b0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      frame_count_q <= '0;
      cs_a_n_q      <= 1'b1;
      cs_b_n_q      <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tgt_q         <= tgt_d;
      upd_q         <= upd_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      frame_count_q <= frame_count_d;
      cs_a_n_q      <= cs_a_n_d;
      cs_b_n_q      <= cs_b_n_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_count = frame_count_q;
  assign spi_cs_a_n  = cs_a_n_q;
  assign spi_cs_b_n  = cs_b_n_q;

endmodule

// File: tb/tb_adc_spi_config_ctrl.sv
// tb_adc_spi_config_ctrl: three DUT configurations (H4/G8/AU0,
// H4/G8/AU1, H1/G1/AU0); frames checked by a scoreboard monitor.
module tb_adc_spi_config_ctrl;

  logic        clk;
  logic        rst;
  logic [2:0]  v;
  logic [1:0]  tgt;
  logic [12:0] addr;
  logic [7:0]  data;
  logic [2:0]  rdy, bsy, dn, sck, sdo, ca, cb;
  logic [15:0] fc0, fc1, fc2;

  int n_cmp = 0;
  int n_bad = 0;
  int sel   = 0;

  typedef struct {
    logic [23:0] frame;
    logic [1:0]  mask;
    int          len;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int          s;
    logic [1:0]  t;
    logic [12:0] a;
    logic [7:0]  d;
    int          e_done;
    int          e_ready;
    int          nfr;
  } vec_t;

  logic [15:0] efc [3];

  adc_spi_config_ctrl #(
    .CLK_DIV(4), .GAP_CYCLES(8), .AUTO_UPDATE(1'b0)
  ) u0 (
    .clk(clk), .rst(rst), .cmd_valid(v[0]), .cmd_ready(rdy[0]),
    .cmd_target(tgt), .cmd_addr(addr), .cmd_data(data),
    .busy(bsy[0]), .done(dn[0]), .frame_count(fc0),
    .spi_sclk(sck[0]), .spi_sdio(sdo[0]),
    .spi_cs_a_n(ca[0]), .spi_cs_b_n(cb[0])
  );

  adc_spi_config_ctrl #(
    .CLK_DIV(4), .GAP_CYCLES(8), .AUTO_UPDATE(1'b1)
  ) u1 (
    .clk(clk), .rst(rst), .cmd_valid(v[1]), .cmd_ready(rdy[1]),
    .cmd_target(tgt), .cmd_addr(addr), .cmd_data(data),
    .busy(bsy[1]), .done(dn[1]), .frame_count(fc1),
    .spi_sclk(sck[1]), .spi_sdio(sdo[1]),
    .spi_cs_a_n(ca[1]), .spi_cs_b_n(cb[1])
  );

  adc_spi_config_ctrl #(
    .CLK_DIV(1), .GAP_CYCLES(1), .AUTO_UPDATE(1'b0)
  ) u2 (
    .clk(clk), .rst(rst), .cmd_valid(v[2]), .cmd_ready(rdy[2]),
    .cmd_target(tgt), .cmd_addr(addr), .cmd_data(data),
    .busy(bsy[2]), .done(dn[2]), .frame_count(fc2),
    .spi_sclk(sck[2]), .spi_sdio(sdo[2]),
    .spi_cs_a_n(ca[2]), .spi_cs_b_n(cb[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int hval(input int s);
    return (s == 2) ? 1 : 4;
  endfunction

  function automatic logic [15:0] fc_of(input int s);
    return (s == 0) ? fc0 : (s == 1) ? fc1 : fc2;
  endfunction

  task automatic check(
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // frame monitor / scoreboard consumer
  logic        p_sck = 1'b0;
  logic        p_sdo = 1'b1;
  logic        m_act = 1'b0;
  logic [23:0] m_bits;
  int          m_n, m_len, m_badm;
  always @(negedge clk) begin
    logic [1:0] lowm;
    exp_t       e;
    if (rst) begin
      m_act = 1'b0;
      p_sck = 1'b0;
      p_sdo = 1'b1;
    end else begin
      lowm = {~cb[sel], ~ca[sel]};
      if (lowm != 2'b00) begin
        if (!m_act) begin
          m_act  = 1'b1;
          m_bits = '0;
          m_n    = 0;
          m_len  = 0;
          m_badm = 0;
        end
        m_len++;
        if (exp_q.size() > 0 && lowm != exp_q[0].mask)
          m_badm++;
        if (sck[sel] && !p_sck) begin
          check("sdio_stable", 32'(sdo[sel]), 32'(p_sdo));
          m_bits = {m_bits[22:0], sdo[sel]};
          m_n++;
        end
      end else if (m_act) begin
        m_act = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'(m_bits), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("frame_bits", 32'(m_bits), 32'(e.frame));
          check("sclk_rises", m_n, 24);
          check("cs_low_len", m_len, e.len);
          check("cs_mask", m_badm, 0);
        end
      end
      p_sck = sck[sel];
      p_sdo = sdo[sel];
    end
  end

  task automatic wait_ready(input int s);
    int k;
    k = 0;
    @(negedge clk);
    while (!rdy[s] && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("wait_ready", 32'(rdy[s]), 32'd1);
  endtask

  task automatic push_exp(
    input int s, input logic [1:0] t,
    input logic [12:0] a, input logic [7:0] d
  );
    exp_t e;
    e.frame = {3'b000, a, d};
    e.mask  = t;
    e.len   = 49 * hval(s);
    exp_q.push_back(e);
  endtask

  task automatic do_cmd(
    input int s, input logic [1:0] t,
    input logic [12:0] a, input logic [7:0] d,
    input int e_done, input int e_ready,
    input int nfr, input int abort_at
  );
    int dcyc, dcnt, rcyc, lowc;
    bit aborted;
    sel = s;
    wait_ready(s);
    tgt  = t;
    addr = a;
    data = d;
    v[s] = 1'b1;
    if (abort_at == 0 && t != 2'b00) begin
      push_exp(s, t, a, d);
      if (nfr == 2) push_exp(s, t, 13'h0FF, 8'h01);
    end
    @(posedge clk);
    dcyc = 0; dcnt = 0; rcyc = 0; lowc = 0;
    aborted = 1'b0;
    for (int c = 1; c <= e_ready + 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        v[s] = 1'b0;
        addr = 13'($urandom);
        data = 8'($urandom);
        tgt  = ~t;
      end
      if (abort_at != 0 && c == abort_at) begin
        rst = 1'b1;
        #1;
        check("rst_cs_a", 32'(ca[s]), 32'd1);
        check("rst_cs_b", 32'(cb[s]), 32'd1);
        check("rst_sclk", 32'(sck[s]), 32'd0);
        check("rst_sdio", 32'(sdo[s]), 32'd1);
        check("rst_ready", 32'(rdy[s]), 32'd1);
        check("rst_busy", 32'(bsy[s]), 32'd0);
        check("rst_done", 32'(dn[s]), 32'd0);
        check("rst_fc", 32'(fc_of(s)), 32'd0);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("rst_no_done", 32'(dn[s]), 32'd0);
        end
        rst = 1'b0;
        efc[0] = '0; efc[1] = '0; efc[2] = '0;
        aborted = 1'b1;
        break;
      end
      if (dn[s]) begin
        dcnt++;
        if (dcyc == 0) dcyc = c;
      end
      if (!ca[s] || !cb[s]) lowc++;
      if (rdy[s]) begin
        rcyc = c;
        break;
      end
    end
    if (!aborted) begin
      efc[s] = efc[s] + 16'(nfr);
      check("done_cycle", dcyc, e_done);
      check("done_count", dcnt, 1);
      check("ready_cycle", rcyc, e_ready);
      check("cs_low_cycles", lowc, nfr * 49 * hval(s));
      check("frame_count", 32'(fc_of(s)), 32'(efc[s]));
    end
  endtask

  vec_t vecs[$];

  initial begin
    int rc, d1, d2;
    vecs = '{
      '{0, 2'b01, 13'h0014, 8'h41, 197, 205, 1},
      '{1, 2'b11, 13'h0014, 8'h41, 401, 409, 2},
      '{0, 2'b00, 13'h0014, 8'h41,   1,   2, 0},
      '{0, 2'b10, 13'h1ABC, 8'h5A, 197, 205, 1},
      '{2, 2'b01, 13'h1FFF, 8'hFF,  50,  51, 1},
      '{2, 2'b11, 13'h0000, 8'h00,  50,  51, 1},
      '{1, 2'b00, 13'h00AA, 8'h11,   1,   2, 0},
      '{1, 2'b01, 13'h1555, 8'hAA, 401, 409, 2},
      '{2, 2'b00, 13'h0001, 8'h80,   1,   2, 0}
    };
    efc[0] = '0; efc[1] = '0; efc[2] = '0;
    rst  = 1'b1;
    v    = '0;
    tgt  = '0;
    addr = '0;
    data = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(rdy[0]), 32'd1);
    check("reset_busy", 32'(bsy[0]), 32'd0);
    check("reset_done", 32'(dn[0]), 32'd0);
    check("reset_fc", 32'(fc0), 32'd0);
    check("reset_sclk", 32'(sck[0]), 32'd0);
    check("reset_sdio", 32'(sdo[0]), 32'd1);
    check("reset_cs_a", 32'(ca[0]), 32'd1);
    check("reset_cs_b", 32'(cb[0]), 32'd1);
    rst = 1'b0;

    foreach (vecs[i])
      do_cmd(vecs[i].s, vecs[i].t, vecs[i].a, vecs[i].d,
             vecs[i].e_done, vecs[i].e_ready, vecs[i].nfr, 0);

    // reset in the middle of a frame, then a normal command
    do_cmd(0, 2'b01, 13'h0333, 8'h77, 197, 205, 1, 100);
    do_cmd(0, 2'b01, 13'h0123, 8'h9C, 197, 205, 1, 0);

    // cmd_valid held high with churning fields
    sel = 0;
    wait_ready(0);
    tgt  = 2'b01;
    addr = 13'h00AA;
    data = 8'h55;
    v[0] = 1'b1;
    push_exp(0, 2'b01, 13'h00AA, 8'h55);
    @(posedge clk);
    rc = 0;
    d1 = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (dn[0] && d1 == 0) d1 = c;
      if (rdy[0]) begin
        rc   = c;
        addr = 13'h1234;
        data = 8'hC3;
        push_exp(0, 2'b01, 13'h1234, 8'hC3);
        break;
      end
      addr = 13'($urandom);
      data = 8'($urandom);
    end
    check("b2b_first_done", d1, 197);
    check("b2b_ready_cycle", rc, 205);
    @(negedge clk);
    v[0] = 1'b0;
    check("b2b_accept_busy", 32'(bsy[0]), 32'd1);
    check("b2b_accept_rdy", 32'(rdy[0]), 32'd0);
    d2 = 0;
    for (int c = 2; c <= 400; c++) begin
      @(negedge clk);
      if (dn[0]) begin
        d2 = c;
        break;
      end
    end
    check("b2b_second_done", d2, 197);
    wait_ready(0);
    efc[0] = efc[0] + 16'd2;
    check("b2b_fc", 32'(fc0), 32'(efc[0]));

    // frame_count wrap
    @(negedge clk);
    force u0.frame_count_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release u0.frame_count_q;
    #1;
    check("fc_preload", 32'(fc0), 32'hFFFF);
    efc[0] = 16'hFFFF;
    do_cmd(0, 2'b10, 13'h0055, 8'hE7, 197, 205, 1, 0);
    check("fc_wrapped", 32'(fc0), 32'd0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
